// File: rtl/switch_debounce_toggle.sv
// ---------------------------------------------------------------------------
// switch_debounce_toggle
//
// Takes the active-high, already-inverted switch level from a pull-up pad.
// The block synchronises it to clk, rejects contact bounce, and then drives
// a clean level, one-cycle press/release pulses, a toggling LED output and a
// wrapping press counter.
//
// Parameters
//   DEBOUNCE_CYCLES : synchronised samples at a new level needed to accept it
//   CNT_WIDTH       : debounce counter width
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous, active-high reset
//   sw_in         in   raw switch level (1 = pressed), asynchronous, bouncy
//   sw_level      out  debounced switch level
//   press_pulse   out  one-cycle pulse on an accepted 0->1 transition
//   release_pulse out  one-cycle pulse on an accepted 1->0 transition
//   led_toggle    out  inverts on every accepted press
//   press_count   out  accepted presses, modulo 256
// ---------------------------------------------------------------------------
module switch_debounce_toggle #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_in,
    output logic       sw_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       led_toggle,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // The sample that moves the FSM into WAIT is already the first sample
    // at the new level, so cnt_r counts the samples seen so far. The sample
    // evaluated in WAIT is one more, so the commit happens at cnt_r = D-1.
    // For D = 1 the commit happens on the first WAIT evaluation.
    localparam logic [CNT_WIDTH-1:0] CNT_COMMIT =
        CNT_WIDTH'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 1) : 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    logic                 s1_r;
    logic                 sw_sync_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 commit_high_s;
    logic                 commit_low_s;

    logic                 sw_level_r;
    logic                 press_pulse_r;
    logic                 release_pulse_r;
    logic                 led_toggle_r;
    logic [7:0]           press_count_r;

    logic                 sw_level_nxt_s;
    logic                 press_pulse_nxt_s;
    logic                 release_pulse_nxt_s;
    logic                 led_toggle_nxt_s;
    logic [7:0]           press_count_nxt_s;

    // Two-flop synchroniser for the asynchronous switch level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= 1'b0;
            sw_sync_r <= 1'b0;
        end else begin
            s1_r      <= sw_in;
            sw_sync_r <= s1_r;
        end
    end

    // State, debounce counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= STABLE_LOW;
            cnt_r           <= CNT_ZERO;
            sw_level_r      <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            led_toggle_r    <= 1'b0;
            press_count_r   <= 8'd0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            sw_level_r      <= sw_level_nxt_s;
            press_pulse_r   <= press_pulse_nxt_s;
            release_pulse_r <= release_pulse_nxt_s;
            led_toggle_r    <= led_toggle_nxt_s;
            press_count_r   <= press_count_nxt_s;
        end
    end

    // Next-state and counter logic; flags the accepted transitions
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = CNT_ZERO;
        commit_high_s = 1'b0;
        commit_low_s  = 1'b0;
        case (state_r)
            STABLE_LOW: begin
                if (sw_sync_r) begin
                    state_nxt_s = WAIT_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = STABLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!sw_sync_r) begin
                    state_nxt_s = STABLE_LOW;
                end else if (cnt_r >= CNT_COMMIT) begin
                    state_nxt_s   = STABLE_HIGH;
                    commit_high_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sw_sync_r) begin
                    state_nxt_s = WAIT_LOW;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = STABLE_HIGH;
                end
            end
            WAIT_LOW: begin
                if (sw_sync_r) begin
                    state_nxt_s = STABLE_HIGH;
                end else if (cnt_r >= CNT_COMMIT) begin
                    state_nxt_s  = STABLE_LOW;
                    commit_low_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = STABLE_LOW;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the commit flags
    always_comb begin
        sw_level_nxt_s      = sw_level_r;
        press_pulse_nxt_s   = 1'b0;
        release_pulse_nxt_s = 1'b0;
        led_toggle_nxt_s    = led_toggle_r;
        press_count_nxt_s   = press_count_r;
        if (commit_high_s) begin
            sw_level_nxt_s    = 1'b1;
            press_pulse_nxt_s = 1'b1;
            led_toggle_nxt_s  = ~led_toggle_r;
            press_count_nxt_s = press_count_r + 8'd1;
        end else if (commit_low_s) begin
            sw_level_nxt_s      = 1'b0;
            release_pulse_nxt_s = 1'b1;
        end else begin
            sw_level_nxt_s = sw_level_r;
        end
    end

    assign sw_level      = sw_level_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign led_toggle    = led_toggle_r;
    assign press_count   = press_count_r;

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_toggle
//
// Drives directed and random switch activity into switch_debounce_toggle
// (DEBOUNCE_CYCLES = 4). Every edge is compared against a reference model.
// The model describes the behaviour in its own terms: the synchroniser is a
// two-entry delay queue. A new level is accepted once the last D
// synchronised samples all differ from the current level.
// ---------------------------------------------------------------------------
module tb_switch_debounce_toggle;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_in;
    logic       sw_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       led_toggle;
    logic [7:0] press_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit pipe[$];
    bit win[$];
    bit m_level;
    bit m_press;
    bit m_rel;
    bit m_led;
    int m_cnt;

    int npress;

    switch_debounce_toggle #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_in         (sw_in),
        .sw_level      (sw_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .led_toggle    (led_toggle),
        .press_count   (press_count)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        total++;
        if (obs != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance the model by one rising edge, using the inputs present at that edge
    task automatic model_edge();
        bit seen;
        bit all_new;
        if (rst) begin
            pipe    = '{1'b0, 1'b0};
            win.delete();
            m_level = 1'b0;
            m_press = 1'b0;
            m_rel   = 1'b0;
            m_led   = 1'b0;
            m_cnt   = 0;
        end else begin
            seen = pipe.pop_front();
            pipe.push_back(sw_in);
            win.push_back(seen);
            if (win.size() > D) void'(win.pop_front());
            m_press = 1'b0;
            m_rel   = 1'b0;
            all_new = (win.size() == D);
            foreach (win[i]) if (win[i] == m_level) all_new = 1'b0;
            if (all_new) begin
                m_level = ~m_level;
                if (m_level) begin
                    m_press = 1'b1;
                    m_led   = ~m_led;
                    m_cnt   = (m_cnt + 1) % 256;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_eq({tag, ".level"}, int'(sw_level),      int'(m_level));
        check_eq({tag, ".press"}, int'(press_pulse),   int'(m_press));
        check_eq({tag, ".rel"},   int'(release_pulse), int'(m_rel));
        check_eq({tag, ".led"},   int'(led_toggle),    int'(m_led));
        check_eq({tag, ".count"}, int'(press_count),   m_cnt);
        if (press_pulse === 1'b1) npress++;
    endtask

    task automatic hold(input bit v, input int n, input string tag);
        sw_in = v;
        repeat (n) step(tag);
    endtask

    initial begin
        pipe = '{1'b0, 1'b0};
        rst   = 1'b1;
        sw_in = 1'b1;

        // switch held pressed through reset
        repeat (3) step("rst_hold");
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step("post_rst");
            if (i == 5) check_eq("post_rst_e5_level", int'(sw_level), 0);
            if (i == 6) check_eq("post_rst_e6_press", int'(press_pulse), 1);
            if (i == 7) begin
                check_eq("post_rst_e7_led",   int'(led_toggle),  1);
                check_eq("post_rst_e7_count", int'(press_count), 1);
            end
        end

        // release, then a clean press and release
        sw_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step("clean_rel0");
            if (i == 5) check_eq("rel_e5_level", int'(sw_level), 1);
            if (i == 6) check_eq("rel_e6_pulse", int'(release_pulse), 1);
        end
        sw_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step("clean_press");
            if (i == 5) check_eq("press_e5_level", int'(sw_level), 0);
            if (i == 6) check_eq("press_e6_pulse", int'(press_pulse), 1);
        end
        hold(1'b0, 10, "clean_rel");

        // bounce 1,0,1,0,1 then hold high
        npress = 0;
        hold(1'b1, 1, "bounce");
        hold(1'b0, 1, "bounce");
        hold(1'b1, 1, "bounce");
        hold(1'b0, 1, "bounce");
        hold(1'b1, 1, "bounce");
        for (int i = 1; i <= 10; i++) begin
            step("bounce_hold");
            if (i == 4) check_eq("bounce_e5_level", int'(sw_level), 0);
            if (i == 5) check_eq("bounce_e6_level", int'(sw_level), 1);
        end
        check_eq("bounce_npress", npress, 1);
        hold(1'b0, 10, "bounce_rel");

        // short glitch, 3 cycles high
        npress = 0;
        hold(1'b1, 3, "glitch");
        hold(1'b0, 10, "glitch_lo");
        check_eq("glitch_npress", npress, 0);

        // 256 presses from reset: wraps back to zero
        rst = 1'b1;
        step("wrap_rst");
        rst = 1'b0;
        hold(1'b0, 3, "wrap_lo");
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 7, "wrap_hi");
            if (k == 254) check_eq("wrap_255", int'(press_count), 255);
            hold(1'b0, 7, "wrap_lo");
        end
        check_eq("wrap_count0", int'(press_count), 0);
        check_eq("wrap_led0",   int'(led_toggle),  0);

        // reset in the middle of WAIT_HIGH
        hold(1'b0, 6, "midw_lo");
        sw_in = 1'b1;
        repeat (4) step("midw_pre");
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("midw_rst");
            check_eq("midw_rst_press", int'(press_pulse), 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step("midw_post");
            check_eq("midw_post_press", int'(press_pulse), (i == 6) ? 1 : 0);
        end

        // random activity with occasional reset
        for (int it = 0; it < 300; it++) begin
            rst   = ($urandom_range(0, 24) == 0);
            sw_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) step("rand");
        end
        rst = 1'b0;
        hold(1'b0, 10, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
